mux4_arbiter: RTL and testbench

Round-robin arbiter that shares one 4:1 `mux4` datapath among four requesters. It drives the mux select `sel` and a one-hot grant, and holds ownership for as long as the owner keeps its request asserted. Ownership passes back-to-back to the next pending requester with no idle cycle. It sits between the requesting units and the `mux4` instance, and `sel` connects directly to the mux `s` input.

---
 rtl/mux4_arbiter.sv | 147 ++++++++++++++
 tb/tb_mux4_arbiter.sv | 115 +++++++++++
 2 files changed

// File: rtl/mux4_arbiter.sv
// Round-robin owner arbiter for a shared mux4 datapath; optional forced release under ARB_TIMEOUT_EN.
// Latency: grant/sel registered, valid one edge after req is sampled; handoff at release has no dead cycle.
// Backpressure: owner holds while its req stays high; others wait (bounded by MAX_HOLD when ARB_TIMEOUT_EN).
module mux4_arbiter #(
  parameter int MAX_HOLD = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  output logic [3:0] grant,
  output logic [1:0] sel,
  output logic       busy,
  output logic       preempt
);

  if (MAX_HOLD < 1 || MAX_HOLD > 255) begin : g_max_hold_chk
    $error("mux4_arbiter: MAX_HOLD must be in 1..255");
  end

  typedef enum logic {IDLE, GRANT} state_t;

  state_t     state_q, state_nxt;
  logic [3:0] grant_q, grant_nxt;
  logic [1:0] sel_q, sel_nxt;
  logic [1:0] last_q, last_nxt;
  logic [3:0] cand;
  logic       do_pick;
  logic [1:0] win;
  logic       owner_req;
  logic       force_rel;

`ifdef ARB_TIMEOUT_EN
  localparam logic [7:0] HOLD_LIM = 8'(MAX_HOLD - 1);
  logic [7:0] hold_q, hold_nxt;
  logic       preempt_q, preempt_nxt;
`endif

  // First set bit of cand, searching from ptr+1 and wrapping 3->0.
  function automatic logic [1:0] rr_pick(input logic [3:0] c, input logic [1:0] ptr);
    logic [1:0] idx;
    logic       found;
    rr_pick = ptr;
    found   = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      idx = ptr + 2'(i);
      if (!found && c[idx]) begin
        rr_pick = idx;
        found   = 1'b1;
      end
    end
  endfunction

  assign owner_req = req[sel_q];

`ifdef ARB_TIMEOUT_EN
  assign force_rel = (state_q == GRANT) && owner_req && (hold_q == HOLD_LIM) &&
                     (|(req & ~grant_q));
`else
  assign force_rel = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      grant_q <= 4'b0000;
      sel_q   <= 2'd0;
      last_q  <= 2'd3;
`ifdef ARB_TIMEOUT_EN
      hold_q    <= 8'd0;
      preempt_q <= 1'b0;
`endif
    end else begin
      state_q <= state_nxt;
      grant_q <= grant_nxt;
      sel_q   <= sel_nxt;
      last_q  <= last_nxt;
`ifdef ARB_TIMEOUT_EN
      hold_q    <= hold_nxt;
      preempt_q <= preempt_nxt;
`endif
    end
  end

  always_comb begin
    state_nxt = state_q;
    grant_nxt = grant_q;
    sel_nxt   = sel_q;
    last_nxt  = last_q;
    cand      = 4'b0000;
    do_pick   = 1'b0;
`ifdef ARB_TIMEOUT_EN
    hold_nxt    = hold_q;
    preempt_nxt = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (|req) begin
          cand    = req;
          do_pick = 1'b1;
        end
      end
      GRANT: begin
        if (!owner_req || force_rel) begin
          // The outgoing owner is masked so a forced release cannot re-grant it.
          cand = req & ~grant_q;
          if (|cand) begin
            do_pick = 1'b1;
          end else begin
            grant_nxt = 4'b0000;
            state_nxt = IDLE;
          end
`ifdef ARB_TIMEOUT_EN
          preempt_nxt = force_rel;
`endif
        end else begin
`ifdef ARB_TIMEOUT_EN
          hold_nxt = (hold_q == 8'hFF) ? hold_q : hold_q + 8'd1;
`endif
        end
      end
      default: state_nxt = IDLE;
    endcase

    win = rr_pick(cand, last_q);
    if (do_pick) begin
      grant_nxt = 4'b0001 << win;
      sel_nxt   = win;
      last_nxt  = win;
      state_nxt = GRANT;
`ifdef ARB_TIMEOUT_EN
      hold_nxt = 8'd0;
`endif
    end
  end

  always_comb begin
    grant = grant_q;
    sel   = sel_q;
    busy  = |grant_q;
`ifdef ARB_TIMEOUT_EN
    preempt = preempt_q;
`else
    preempt = 1'b0;
`endif
  end

endmodule

// File: tb/tb_mux4_arbiter.sv
// Directed bench for mux4_arbiter: expectations queued at drive time, popped and compared after each edge.
module tb_mux4_arbiter;
  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req;
  logic [3:0] grant;
  logic [1:0] sel;
  logic       busy;
  logic       preempt;

  typedef struct packed {
    logic [3:0] grant;
    logic [1:0] sel;
    logic       preempt;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  logic [3:0] eg;
  logic [1:0] es;
  logic       ep;

  always #5 clk = ~clk;

  mux4_arbiter #(.MAX_HOLD(4)) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .grant   (grant),
    .sel     (sel),
    .busy    (busy),
    .preempt (preempt)
  );

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one edge's inputs, queue the expected post-edge outputs, then compare after the edge.
  task automatic step(input logic r, input logic [3:0] q, input logic [3:0] xg,
                      input logic [1:0] xs, input logic xp, input string tag);
    exp_t e;
    rst = r;
    req = q;
    sb_q.push_back('{grant: xg, sel: xs, preempt: xp});
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    check({tag, ".grant"},   8'(grant),   8'(e.grant));
    check({tag, ".sel"},     8'(sel),     8'(e.sel));
    check({tag, ".busy"},    8'(busy),    8'(|e.grant));
    check({tag, ".preempt"}, 8'(preempt), 8'(e.preempt));
  endtask

  initial begin
    rst = 1'b1;
    req = 4'b0000;

    // Reset then idle
    step(1'b1, 4'b0000, 4'b0000, 2'd0, 1'b0, "rst0");
    step(1'b1, 4'b0000, 4'b0000, 2'd0, 1'b0, "rst1");
    step(1'b0, 4'b0000, 4'b0000, 2'd0, 1'b0, "idle");

    // Single requester: grant edge plus 5 held edges -> 6 grant cycles
    for (int i = 0; i < 6; i++) step(1'b0, 4'b0100, 4'b0100, 2'd2, 1'b0, "single");
    step(1'b0, 4'b0000, 4'b0000, 2'd2, 1'b0, "single_rel");
    step(1'b0, 4'b0000, 4'b0000, 2'd2, 1'b0, "single_idle");

    // Round robin after reset: each owner drops its bit for one edge
    step(1'b1, 4'b0000, 4'b0000, 2'd0, 1'b0, "rr_rst");
    step(1'b0, 4'b1111, 4'b0001, 2'd0, 1'b0, "rr0");
    step(1'b0, 4'b1110, 4'b0010, 2'd1, 1'b0, "rr1");
    step(1'b0, 4'b1101, 4'b0100, 2'd2, 1'b0, "rr2");
    step(1'b0, 4'b1011, 4'b1000, 2'd3, 1'b0, "rr3");
    step(1'b0, 4'b0111, 4'b0001, 2'd0, 1'b0, "rr4");

    // Back-to-back handoff 1 -> 3 with req[3] rising mid-grant
    step(1'b0, 4'b0010, 4'b0010, 2'd1, 1'b0, "b2b_own1");
    step(1'b0, 4'b0010, 4'b0010, 2'd1, 1'b0, "b2b_hold");
    step(1'b0, 4'b1010, 4'b0010, 2'd1, 1'b0, "b2b_mid");
    step(1'b0, 4'b1000, 4'b1000, 2'd3, 1'b0, "b2b_hand");

    // Reset mid-grant
    step(1'b0, 4'b0010, 4'b0010, 2'd1, 1'b0, "mid_own1");
    step(1'b1, 4'b1111, 4'b0000, 2'd0, 1'b0, "mid_rst");
    step(1'b0, 4'b1111, 4'b0001, 2'd0, 1'b0, "mid_first");

    // Contention with req=0011 held continuously
    step(1'b1, 4'b0000, 4'b0000, 2'd0, 1'b0, "to_rst");
    for (int i = 1; i <= 10; i++) begin
`ifdef ARB_TIMEOUT_EN
      es = 2'(((i - 1) / 4) % 2);
      ep = (i > 1) && (((i - 1) % 4) == 0);
`else
      es = 2'd0;
      ep = 1'b0;
`endif
      eg = 4'b0001 << es;
      step(1'b0, 4'b0011, eg, es, ep, "timeout");
    end

    // Lone owner past MAX_HOLD keeps the grant
    for (int i = 0; i < 6; i++) step(1'b0, 4'b0001, 4'b0001, 2'd0, 1'b0, "lone");
    step(1'b0, 4'b0000, 4'b0000, 2'd0, 1'b0, "lone_rel");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
